// File: rtl/pid_pwm_actuator.sv
// pid_pwm_actuator: double-buffered, slew-limited sign/magnitude PWM driver
// with dead time on direction reversal. Control words are applied only at
// PWM period boundaries.
module pid_pwm_actuator #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned SLEW_MAX = 8,
    parameter int unsigned DEAD     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] ctrl_in,
    input  logic             ctrl_valid,
    output logic             ctrl_ready,
    output logic             pwm,
    output logic             dir,
    output logic             period_start,
    output logic [WIDTH-2:0] duty
);

    localparam int unsigned MW = WIDTH - 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW = (DEAD > 1) ? $clog2(DEAD) : 1;

    localparam logic [MW-1:0] CNT_MAX   = MW'((1 << MW) - 2);
    localparam logic [MW-1:0] MAG_MAX   = '1;
    localparam logic [MW-1:0] SLEW      = MW'(SLEW_MAX);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        REVERSE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [MW-1:0]    cnt_q, cnt_d;
    logic [MW-1:0]    duty_q, duty_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             rdy_q, rdy_d;
    logic             dir_q, dir_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;

    logic             tick;
    logic             boundary;
    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] eff_target;
    logic [WIDTH-1:0] abs_w;
    logic             tgt_neg;
    logic [MW-1:0]    tgt_mag;
    logic             same_dir;
    logic [MW-1:0]    slew_tgt;
    logic [MW-1:0]    duty_step;

    // Timing strobes and the saturated magnitude/sign of the word in effect
    always_comb begin
        tick       = (presc_q == PRE_LAST) && (state_q != IDLE);
        boundary   = tick && (state_q == RUN) && (cnt_q == CNT_MAX);
        eff_target = (boundary && pend_full_q) ? pend_q : target_q;
        tgt_neg    = eff_target[WIDTH-1];
        abs_w      = tgt_neg ? (WIDTH'(0) - eff_target) : eff_target;
        tgt_mag    = abs_w[WIDTH-1] ? MAG_MAX : abs_w[MW-1:0];
        same_dir   = (tgt_neg == dir_q) || (tgt_mag == '0);
        // Opposite sign: bleed duty down to zero before reversing
        slew_tgt   = same_dir ? tgt_mag : '0;
    end

    // One slew-limited step of duty toward slew_tgt
    always_comb begin
        if (slew_tgt > duty_q) begin
            duty_step = ((slew_tgt - duty_q) > SLEW) ? (duty_q + SLEW) : slew_tgt;
        end else begin
            duty_step = ((duty_q - slew_tgt) > SLEW) ? (duty_q - SLEW) : slew_tgt;
        end
    end

    // Pending-buffer handshake; ready is a pure register of buffer emptiness
    always_comb begin
        accept      = ctrl_valid && rdy_q;
        consume     = boundary && pend_full_q && enable;
        pend_d      = accept ? ctrl_in : pend_q;
        pend_full_d = pend_full_q;
        if (consume) begin
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_full_d = 1'b1;
        end
        rdy_d = !pend_full_d;
    end

    // Period/dead-time sequencing and duty/direction updates
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        target_d = target_q;
        dead_d   = dead_q;
        ps_d     = 1'b0;
        pwm_d    = enable && (state_q == RUN) && (cnt_q < duty_q);

        if (!enable) begin
            state_d  = IDLE;
            presc_d  = '0;
            cnt_d    = '0;
            duty_d   = '0;
            target_d = '0;
            dead_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    presc_d = '0;
                    cnt_d   = '0;
                    duty_d  = '0;
                end
                RUN: begin
                    presc_d = tick ? '0 : (presc_q + PW'(1));
                    if (tick) begin
                        if (cnt_q == CNT_MAX) begin
                            cnt_d    = '0;
                            ps_d     = 1'b1;
                            target_d = eff_target;
                            if (same_dir || (duty_q != '0)) begin
                                duty_d = duty_step;
                            end else begin
                                state_d = REVERSE;
                                dead_d  = '0;
                            end
                        end else begin
                            cnt_d = cnt_q + MW'(1);
                        end
                    end
                end
                REVERSE: begin
                    presc_d = tick ? '0 : (presc_q + PW'(1));
                    cnt_d   = '0;
                    if (tick) begin
                        if (dead_q == DEAD_LAST) begin
                            state_d = RUN;
                            dir_d   = tgt_neg;
                            dead_d  = '0;
                            ps_d    = 1'b1;
                        end else begin
                            dead_d = dead_q + DW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            cnt_q       <= '0;
            duty_q      <= '0;
            dead_q      <= '0;
            target_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            rdy_q       <= 1'b0;
            dir_q       <= 1'b0;
            pwm_q       <= 1'b0;
            ps_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            dead_q      <= dead_d;
            target_q    <= target_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            rdy_q       <= rdy_d;
            dir_q       <= dir_d;
            pwm_q       <= pwm_d;
            ps_q        <= ps_d;
        end
    end

    assign ctrl_ready   = rdy_q;
    assign pwm          = pwm_q;
    assign dir          = dir_q;
    assign period_start = ps_q;
    assign duty         = duty_q;

endmodule

// File: tb/tb_pid_pwm_actuator.sv
// Testbench for pid_pwm_actuator: directed vector table, hand-written corner
// sequences and randomized words checked by a period-level reference model.
module tb_pid_pwm_actuator;

    localparam int W    = 8;
    localparam int PRE  = 1;
    localparam int SLEW = 8;
    localparam int DEAD = 2;
    localparam int PER  = 127;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] ctrl_in = 8'd0;
    logic       ctrl_valid = 1'b0;
    logic       ctrl_ready;
    logic       pwm;
    logic       dir;
    logic       period_start;
    logic [6:0] duty;

    pid_pwm_actuator #(
        .WIDTH(W), .PRESCALE(PRE), .SLEW_MAX(SLEW), .DEAD(DEAD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .pwm(pwm), .dir(dir), .period_start(period_start), .duty(duty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        int         n;
        int         exp_duty;
        logic       exp_dir;
    } vec_t;

    vec_t tbl [7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state (one update per period boundary)
    bit         model_on = 0;
    int         m_duty = 0;
    bit         m_dir = 0;
    bit         m_tdir = 0;
    int         m_target = 0;
    logic [7:0] m_pend = 8'd0;
    bit         m_pend_full = 0;
    bit         m_rev = 0;
    bit         prev_ready = 0;
    bit         prev_dir = 0;
    bit         last_acc = 0;
    bit         have_prev = 0;
    int         last_ps = 0;
    int         exp_int = 0;
    int         exp_pwm = 0;
    int         pwm_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    function automatic int toward(input int cur, input int tgt);
        if (tgt - cur > SLEW) return cur + SLEW;
        if (cur - tgt > SLEW) return cur - SLEW;
        return tgt;
    endfunction

    function automatic int mag_of(input int t);
        if (t == -128) return 127;
        return (t < 0) ? -t : t;
    endfunction

    // One clock: sample at the falling edge and advance the model
    task automatic step();
        bit acc;
        int mag;
        @(negedge clk);
        cyc++;
        last_acc = 0;
        if (model_on) begin
            pwm_cnt += int'(pwm);
            if (dir != prev_dir) check("pwm_at_dir_flip", int'(pwm), 0);
            prev_dir = dir;
            acc = ctrl_valid && prev_ready;
            if (period_start) begin
                if (m_rev) begin
                    m_rev = 0;
                    m_dir = m_tdir;
                end else begin
                    if (m_pend_full) begin
                        m_target    = int'($signed(m_pend));
                        m_pend_full = 0;
                    end
                    mag    = mag_of(m_target);
                    m_tdir = (m_target < 0);
                    if (m_tdir == m_dir || mag == 0) m_duty = toward(m_duty, mag);
                    else if (m_duty > 0)             m_duty = toward(m_duty, 0);
                    else                             m_rev = 1;
                end
                check("ps_duty", int'(duty), m_duty);
                check("ps_dir", int'(dir), int'(m_dir));
                if (have_prev) begin
                    check("ps_interval", cyc - last_ps, exp_int);
                    check("pwm_high_count", pwm_cnt, exp_pwm);
                end
                exp_int   = m_rev ? DEAD * PRE : PER * PRE;
                exp_pwm   = m_rev ? 0 : m_duty;
                last_ps   = cyc;
                pwm_cnt   = 0;
                have_prev = 1;
            end
            if (acc) begin
                m_pend      = ctrl_in;
                m_pend_full = 1;
            end
            last_acc = acc;
            check("ready", int'(ctrl_ready), m_pend_full ? 0 : 1);
            prev_ready = !m_pend_full;
        end
    endtask

    task automatic send(input logic [7:0] w);
        ctrl_in    = w;
        ctrl_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) fail("send_accept");
        ctrl_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n * (PER * PRE + 10) + 20 && seen < n; i++) begin
            step();
            if (period_start) seen++;
        end
        if (seen < n) fail("period_wait");
    endtask

    function automatic logic [7:0] pick_word();
        case ($urandom_range(5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int ps_seen;

        tbl[0] = '{8'd40,  5,  40,  1'b0};
        tbl[1] = '{8'd16,  3,  16,  1'b0};
        tbl[2] = '{8'hE8,  7,  24,  1'b1};
        tbl[3] = '{8'h80,  13, 127, 1'b1};
        tbl[4] = '{8'h7F,  20, 16,  1'b0};
        tbl[5] = '{8'h00,  2,  0,   1'b0};
        tbl[6] = '{8'hFB,  3,  5,   1'b1};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) step();
        check("rst_pwm", int'(pwm), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_ready", int'(ctrl_ready), 0);
        rst_n = 1'b1;
        step();
        step();
        check("release_ready", int'(ctrl_ready), 1);
        ps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (period_start) ps_seen++;
        end
        check("idle_ps_after_reset", ps_seen, 0);

        // Directed vector table
        model_on   = 1;
        prev_ready = 1;
        prev_dir   = dir;
        enable     = 1'b1;
        foreach (tbl[i]) begin
            send(tbl[i].word);
            wait_pulses(tbl[i].n);
            check($sformatf("vec%0d_duty", i), int'(duty), tbl[i].exp_duty);
            check($sformatf("vec%0d_dir", i), int'(dir), int'(tbl[i].exp_dir));
        end

        // Backpressure: hold the next word until the buffer drains
        send(8'd100);
        ctrl_in    = 8'hF0;
        ctrl_valid = 1'b1;
        ps_seen    = 0;
        for (int i = 0; i < 300 && ps_seen == 0; i++) begin
            step();
            if (period_start) ps_seen = 1;
            else check("bp_ready_low", int'(ctrl_ready), 0);
        end
        if (ps_seen == 0) fail("bp_boundary");
        check("bp_ready_back", int'(ctrl_ready), 1);
        check("bp_duty_toward0", int'(duty), 0);
        step();
        check("bp_accept_next", int'(last_acc), 1);
        check("bp_ready_taken", int'(ctrl_ready), 0);
        ctrl_valid = 1'b0;
        wait_pulses(1);
        check("bp_duty_a", int'(duty), 8);
        check("bp_dir", int'(dir), 1);
        wait_pulses(1);
        check("bp_duty_b", int'(duty), 16);

        // Disable mid-period, queue a word while idle, re-enable
        send(8'hD8);
        wait_pulses(3);
        check("dis_pre_duty", int'(duty), 40);
        repeat (20) step();
        check("dis_pre_pwm", int'(pwm), 1);
        enable    = 1'b0;
        m_duty    = 0;
        m_target  = 0;
        m_rev     = 0;
        have_prev = 0;
        step();
        check("dis_pwm", int'(pwm), 0);
        check("dis_duty", int'(duty), 0);
        send(8'hE8);
        ps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (period_start) ps_seen++;
        end
        check("dis_idle_ps", ps_seen, 0);
        enable = 1'b1;
        wait_pulses(1);
        check("reen_duty", int'(duty), 8);
        check("reen_dir", int'(dir), 1);

        // Randomized words against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            if (last_acc) ctrl_valid = 1'b0;
            else if (ctrl_valid && $urandom_range(15) == 0) ctrl_valid = 1'b0;
            if (!ctrl_valid && $urandom_range(30) == 0) begin
                ctrl_in    = pick_word();
                ctrl_valid = 1'b1;
            end
        end
        ctrl_valid = 1'b0;

        // Async reset while pwm is high
        send(8'h7F);
        begin
            bit hi;
            hi = 0;
            for (int i = 0; i < 6000 && !hi; i++) begin
                step();
                if (pwm) hi = 1;
            end
            if (!hi) fail("wait_pwm_high");
        end
        #2 rst_n = 1'b0;
        model_on = 0;
        #1;
        check("async_pwm", int'(pwm), 0);
        check("async_dir", int'(dir), 0);
        check("async_duty", int'(duty), 0);
        check("async_ready", int'(ctrl_ready), 0);
        check("async_ps", int'(period_start), 0);
        enable = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();
        check("async_release_ready", int'(ctrl_ready), 1);
        ps_seen = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (period_start) ps_seen++;
        end
        check("async_idle_ps", ps_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
